// File: rtl/cpu_trap_ctrl.sv
// Trap controller for an out-of-order core: arbitrates interrupts, drains the ROB,
// takes exceptions, sequences mret, and drives the CSR update and fetch redirect.
module cpu_trap_ctrl #(
  parameter int NUM_INT       = 3,
  parameter int PC_WIDTH      = 32,
  parameter int INT_CODE_BASE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INT-1:0]  int_pending,
  input  logic [NUM_INT-1:0]  int_enable,
  input  logic                mstatus_mie,
  input  logic                rob_empty,
  input  logic                rob_commit_valid,
  input  logic [PC_WIDTH-1:0] rob_commit_pc,
  input  logic                rob_commit_exp_en,
  input  logic [4:0]          rob_commit_exp_cause,
  input  logic                rob_commit_mret,
  input  logic [29:0]         csr_mtvec_base,
  input  logic [1:0]          csr_mtvec_mode,
  input  logic [PC_WIDTH-1:0] csr_mepc_pc,
  output logic                fetch_stall,
  output logic                flush_all,
  output logic                redirect_en,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                mie_clear_en,
  output logic                mie_set_en,
  output logic                mepc_set_en,
  output logic                mcause_set_en,
  output logic [PC_WIDTH-1:0] mepc_set_pc,
  output logic [31:0]         mcause_set_cause,
  output logic [NUM_INT-1:0]  int_clear,
  output logic                in_handler,
  output logic [1:0]          state
);

  localparam int ID_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    TRAP    = 2'd2,
    HANDLER = 2'd3
  } state_t;

  state_t              cur, nxt;
  logic [ID_W-1:0]     id_q;
  logic                act_int;
  logic [PC_WIDTH-1:0] trap_pc;
  logic [4:0]          trap_cause;
  logic [PC_WIDTH-1:0] last_pc;

  logic [NUM_INT-1:0]  masked;
  logic [ID_W-1:0]     winner;
  logic                int_req;
  logic                commit_exc, commit_mret, commit_ok;
  logic                take_exc, take_int, start_drain, do_mret;
  logic [31:0]         int_code;
  logic [PC_WIDTH-1:0] tvec_pc, vec_off;

  assign masked      = int_pending & int_enable;
  assign int_req     = mstatus_mie && (|masked);
  assign commit_exc  = rob_commit_valid && rob_commit_exp_en;
  assign commit_mret = rob_commit_valid && rob_commit_mret && !rob_commit_exp_en;
  assign commit_ok   = rob_commit_valid && !rob_commit_exp_en;

  // Scan from the top so the lowest pending index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (masked[i]) winner = ID_W'(i);
    end
  end

  assign int_code = 32'(INT_CODE_BASE) + 32'(id_q);
  assign tvec_pc  = PC_WIDTH'({csr_mtvec_base, 2'b00});
  assign vec_off  = PC_WIDTH'({int_code, 2'b00});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur        <= IDLE;
      id_q       <= '0;
      act_int    <= 1'b0;
      trap_pc    <= '0;
      trap_cause <= '0;
      last_pc    <= '0;
    end else begin
      cur <= nxt;
      if (commit_ok) last_pc <= rob_commit_pc;
      if (start_drain) id_q <= winner;
      if (take_int) act_int <= 1'b1;
      if (take_exc) begin
        act_int    <= 1'b0;
        trap_pc    <= rob_commit_pc;
        trap_cause <= rob_commit_exp_cause;
      end
      if (do_mret) begin
        act_int <= 1'b0;
        id_q    <= '0;
      end
    end
  end

  always_comb begin
    nxt         = cur;
    take_exc    = 1'b0;
    take_int    = 1'b0;
    start_drain = 1'b0;
    do_mret     = 1'b0;
    unique case (cur)
      IDLE: begin
        if (commit_exc)       take_exc    = 1'b1;
        else if (commit_mret) do_mret     = 1'b1;
        else if (int_req)     start_drain = 1'b1;
      end
      DRAIN: begin
        if (commit_exc)     take_exc = 1'b1;
        else if (rob_empty) take_int = 1'b1;
      end
      TRAP: nxt = HANDLER;
      HANDLER: begin
        if (commit_exc)       take_exc = 1'b1;
        else if (commit_mret) do_mret  = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (take_exc || take_int) nxt = TRAP;
    else if (do_mret)         nxt = IDLE;
    else if (start_drain)     nxt = DRAIN;
  end

  // Everything is forced low while reset is asserted, including mret pulses.
  always_comb begin
    fetch_stall      = 1'b0;
    flush_all        = 1'b0;
    redirect_en      = 1'b0;
    redirect_pc      = '0;
    mie_clear_en     = 1'b0;
    mie_set_en       = 1'b0;
    mepc_set_en      = 1'b0;
    mcause_set_en    = 1'b0;
    mepc_set_pc      = '0;
    mcause_set_cause = '0;
    int_clear        = '0;
    in_handler       = 1'b0;
    state            = 2'd0;
    if (rst_n) begin
      state       = cur;
      fetch_stall = (cur == DRAIN);
      in_handler  = (cur == HANDLER);
      if (cur == TRAP) begin
        redirect_en   = 1'b1;
        flush_all     = 1'b1;
        mie_clear_en  = 1'b1;
        mepc_set_en   = 1'b1;
        mcause_set_en = 1'b1;
        if (act_int) begin
          mepc_set_pc      = last_pc + PC_WIDTH'(4);
          mcause_set_cause = {1'b1, int_code[30:0]};
          redirect_pc      = (csr_mtvec_mode == 2'd1) ? tvec_pc + vec_off : tvec_pc;
        end else begin
          mepc_set_pc      = trap_pc;
          mcause_set_cause = {1'b0, 26'b0, trap_cause};
          redirect_pc      = tvec_pc;
        end
      end
      if (do_mret) begin
        redirect_en = 1'b1;
        flush_all   = 1'b1;
        mie_set_en  = 1'b1;
        redirect_pc = csr_mepc_pc;
        if (cur == HANDLER && act_int) int_clear = NUM_INT'(1) << id_q;
      end
    end
  end

endmodule
